cache_control: RTL and testbench



---
 rtl/cache_control_if.sv | 26 ++
 rtl/cache_control.sv | 183 ++++++++++++++++++
 tb/tb_cache_control.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_control_if.sv
// CPU-side request/response and physical-memory-side line transfer handshakes
// of the L1 cache controller, bundled so the controller and its neighbours share one bus.
interface cache_control_if #(
    parameter int ADDR_W = 16
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic              pmem_resp;

    // slave: the cache controller; master: the CPU and physical memory around it
    modport slave (
        input  mem_read, mem_write, mem_address, pmem_resp,
        output mem_resp, pmem_read, pmem_write, pmem_address
    );

    modport master (
        output mem_read, mem_write, mem_address, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, pmem_address
    );
endinterface

// File: rtl/cache_control.sv
// Control FSM for the 2-way, 8-set, 16-byte-line write-back/write-allocate L1 cache:
// drives datapath controls, runs CPU and physical-memory handshakes, keeps perf counters.
module cache_control #(
    parameter int TAG_W = 9,
    parameter int IDX_W = 3,
    parameter int OFF_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    cache_control_if.slave   bus,

    input  logic             hit,
    input  logic             set_one_hit,
    input  logic             set_two_hit,
    input  logic             set_one_valid,
    input  logic             set_two_valid,
    input  logic             set_one_dirty,
    input  logic             set_two_dirty,
    input  logic             current_lru,
    input  logic [TAG_W-1:0] set_one_tag,
    input  logic [TAG_W-1:0] set_two_tag,

    output logic             load_set_one,
    output logic             load_set_two,
    output logic             load_lru,
    output logic             cache_in_mux_sel,
    output logic             insert_mux_sel,
    output logic             insert_enable,
    output logic             write_type_set_one,
    output logic             write_type_set_two,
    output logic             pmem_w_mux_sel,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);
    localparam int ADDR_W = TAG_W + IDX_W + OFF_W;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        FILL
    } state_e;

    state_e           state_q, state_d;
    logic             victim_q, victim_d;
    // set while re-comparing after a fill, so the guaranteed hit is not counted
    logic             refill_q, refill_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;
    logic [CNT_W-1:0] wb_count_q, wb_count_d;

    logic              hit_inc, miss_inc, wb_inc;
    logic              victim_dirty;
    logic [TAG_W-1:0]  victim_tag;
    logic [IDX_W-1:0]  set_idx;
    logic              mem_resp_o, pmem_read_o, pmem_write_o;
    logic [ADDR_W-1:0] pmem_address_o;
    logic              unused_offset;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             enable);
        return (enable && (value != {CNT_W{1'b1}})) ? value + CNT_W'(1) : value;
    endfunction

    assign set_idx       = bus.mem_address[OFF_W +: IDX_W];
    assign victim_tag    = victim_q ? set_two_tag : set_one_tag;
    assign victim_dirty  = current_lru ? (set_two_valid && set_two_dirty)
                                       : (set_one_valid && set_one_dirty);
    assign unused_offset = ^bus.mem_address[OFF_W-1:0];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d            = state_q;
        victim_d           = victim_q;
        refill_d           = refill_q;
        hit_inc            = 1'b0;
        miss_inc           = 1'b0;
        wb_inc             = 1'b0;
        mem_resp_o         = 1'b0;
        pmem_read_o        = 1'b0;
        pmem_write_o       = 1'b0;
        pmem_address_o     = '0;
        load_set_one       = 1'b0;
        load_set_two       = 1'b0;
        load_lru           = 1'b0;
        cache_in_mux_sel   = 1'b0;
        insert_enable      = 1'b0;
        write_type_set_one = 1'b0;
        write_type_set_two = 1'b0;
        pmem_w_mux_sel     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                if (hit) begin
                    mem_resp_o = 1'b1;
                    load_lru   = 1'b1;
                    hit_inc    = !refill_q;
                    refill_d   = 1'b0;
                    state_d    = IDLE;
                    // read+write together is a write; set one wins a double hit
                    if (bus.mem_write) begin
                        cache_in_mux_sel = 1'b1;
                        insert_enable    = 1'b1;
                        if (set_one_hit) begin
                            load_set_one       = 1'b1;
                            write_type_set_one = 1'b1;
                        end else if (set_two_hit) begin
                            load_set_two       = 1'b1;
                            write_type_set_two = 1'b1;
                        end
                    end
                end else begin
                    miss_inc = !refill_q;
                    victim_d = current_lru;
                    state_d  = victim_dirty ? WRITEBACK : FILL;
                end
            end

            WRITEBACK: begin
                pmem_write_o   = 1'b1;
                pmem_w_mux_sel = victim_q;
                pmem_address_o = {victim_tag, set_idx, {OFF_W{1'b0}}};
                if (bus.pmem_resp) begin
                    wb_inc  = 1'b1;
                    state_d = FILL;
                end
            end

            FILL: begin
                pmem_read_o    = 1'b1;
                pmem_address_o = {bus.mem_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                if (bus.pmem_resp) begin
                    load_set_one = !victim_q;
                    load_set_two = victim_q;
                    refill_d     = 1'b1;
                    state_d      = COMPARE;
                end
            end

            default: state_d = IDLE;
        endcase

        hit_count_d  = sat_inc(hit_count_q, hit_inc);
        miss_count_d = sat_inc(miss_count_q, miss_inc);
        wb_count_d   = sat_inc(wb_count_q, wb_inc);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            victim_q     <= 1'b0;
            refill_q     <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            refill_q     <= refill_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign bus.mem_resp     = mem_resp_o;
    assign bus.pmem_read    = pmem_read_o;
    assign bus.pmem_write   = pmem_write_o;
    assign bus.pmem_address = pmem_address_o;
    assign insert_mux_sel   = 1'b0;
    assign hit_count        = hit_count_q;
    assign miss_count       = miss_count_q;
    assign wb_count         = wb_count_q;
endmodule

// File: tb/tb_cache_control.sv
// Randomized bench for cache_control: a small datapath model answers the controller, and a
// transaction-level cache reference predicts hits, victims, memory traffic and counters.
module tb_cache_control;
    localparam int TAG_W   = 9;
    localparam int IDX_W   = 3;
    localparam int OFF_W   = 4;
    localparam int CNT_W   = 12;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cache_control_if #(.ADDR_W(16)) bus ();

    logic             hit, set_one_hit, set_two_hit;
    logic             set_one_valid, set_two_valid, set_one_dirty, set_two_dirty, current_lru;
    logic [TAG_W-1:0] set_one_tag, set_two_tag;
    logic             load_set_one, load_set_two, load_lru, cache_in_mux_sel, insert_mux_sel;
    logic             insert_enable, write_type_set_one, write_type_set_two, pmem_w_mux_sel;
    logic [CNT_W-1:0] hit_count, miss_count, wb_count;

    cache_control #(.TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .bus                (bus),
        .hit                (hit),
        .set_one_hit        (set_one_hit),
        .set_two_hit        (set_two_hit),
        .set_one_valid      (set_one_valid),
        .set_two_valid      (set_two_valid),
        .set_one_dirty      (set_one_dirty),
        .set_two_dirty      (set_two_dirty),
        .current_lru        (current_lru),
        .set_one_tag        (set_one_tag),
        .set_two_tag        (set_two_tag),
        .load_set_one       (load_set_one),
        .load_set_two       (load_set_two),
        .load_lru           (load_lru),
        .cache_in_mux_sel   (cache_in_mux_sel),
        .insert_mux_sel     (insert_mux_sel),
        .insert_enable      (insert_enable),
        .write_type_set_one (write_type_set_one),
        .write_type_set_two (write_type_set_two),
        .pmem_w_mux_sel     (pmem_w_mux_sel),
        .hit_count          (hit_count),
        .miss_count         (miss_count),
        .wb_count           (wb_count)
    );

    // datapath arrays, changed only by the controller's load strobes (and by preloads)
    logic       dp_valid [2][8];
    logic       dp_dirty [2][8];
    logic [8:0] dp_tag   [2][8];
    logic       dp_lru   [8];
    // transaction-level reference cache
    logic       rf_valid [2][8];
    logic       rf_dirty [2][8];
    logic [8:0] rf_tag   [2][8];
    logic       rf_lru   [8];
    int         rf_hits, rf_misses, rf_wbs;

    logic [2:0] cur_idx;
    logic [8:0] cur_tag;
    assign cur_idx = bus.mem_address[6:4];
    assign cur_tag = bus.mem_address[15:7];

    always_comb begin
        set_one_valid = dp_valid[0][cur_idx];
        set_two_valid = dp_valid[1][cur_idx];
        set_one_dirty = dp_dirty[0][cur_idx];
        set_two_dirty = dp_dirty[1][cur_idx];
        set_one_tag   = dp_tag[0][cur_idx];
        set_two_tag   = dp_tag[1][cur_idx];
        set_one_hit   = dp_valid[0][cur_idx] && (dp_tag[0][cur_idx] == cur_tag);
        set_two_hit   = dp_valid[1][cur_idx] && (dp_tag[1][cur_idx] == cur_tag);
        hit           = set_one_hit || set_two_hit;
        current_lru   = dp_lru[cur_idx];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    logic       p_ld1, p_ld2, p_wt1, p_wt2, p_lru, p_hit1;
    logic [2:0] p_idx;
    logic [8:0] p_tag;

    task automatic capture_loads();
        p_ld1  = load_set_one;
        p_ld2  = load_set_two;
        p_wt1  = write_type_set_one;
        p_wt2  = write_type_set_two;
        p_lru  = load_lru;
        p_hit1 = set_one_hit;
        p_idx  = cur_idx;
        p_tag  = cur_tag;
    endtask

    task automatic apply_loads();
        if (p_ld1) begin
            if (p_wt1) dp_dirty[0][p_idx] = 1'b1;
            else begin
                dp_valid[0][p_idx] = 1'b1;
                dp_dirty[0][p_idx] = 1'b0;
                dp_tag[0][p_idx]   = p_tag;
            end
        end
        if (p_ld2) begin
            if (p_wt2) dp_dirty[1][p_idx] = 1'b1;
            else begin
                dp_valid[1][p_idx] = 1'b1;
                dp_dirty[1][p_idx] = 1'b0;
                dp_tag[1][p_idx]   = p_tag;
            end
        end
        if (p_lru) dp_lru[p_idx] = p_hit1;
        {p_ld1, p_ld2, p_wt1, p_wt2, p_lru} = '0;
    endtask

    // advance to the next cycle's negedge, with the datapath updated at the edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
        bus.pmem_resp = 1'b0;
        apply_loads();
        @(negedge clk);
    endtask

    function automatic logic [11:0] out_vec();
        return {bus.mem_resp, bus.pmem_read, bus.pmem_write, load_set_one, load_set_two,
                load_lru, cache_in_mux_sel, insert_mux_sel, insert_enable,
                write_type_set_one, write_type_set_two, pmem_w_mux_sel};
    endfunction

    function automatic int sat(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic preload(input int way, input int idx, input logic [8:0] tag,
                           input logic dirty);
        dp_valid[way][idx] = 1'b1; rf_valid[way][idx] = 1'b1;
        dp_dirty[way][idx] = dirty; rf_dirty[way][idx] = dirty;
        dp_tag[way][idx]   = tag;   rf_tag[way][idx]   = tag;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hits"},   32'(hit_count),  rf_hits);
        check({tag, "_misses"}, 32'(miss_count), rf_misses);
        check({tag, "_wbs"},    32'(wb_count),   rf_wbs);
    endtask

    // one CPU request end to end, predicted from the reference cache
    task automatic run_req(input logic wr, input logic both, input logic [15:0] addr);
        logic [2:0]  idx;
        logic [8:0]  tg;
        int          v, w, fill_c, resp_c, pm_cnt, pm_tgt;
        logic        exp_hit, exp_wb, wb_seen, fill_seen, done, stray, wb_sel_obs;
        logic [15:0] exp_wb_addr, exp_fill_addr, wb_addr_obs, fill_addr_obs;
        logic [8:0]  got_ctl, exp_ctl;
        logic [6:0]  got_fill, exp_fill;

        idx = addr[6:4];
        tg  = addr[15:7];
        v   = int'(rf_lru[idx]);
        exp_hit = 1'b0;
        w = v;
        if (rf_valid[0][idx] && rf_tag[0][idx] == tg) begin exp_hit = 1'b1; w = 0; end
        else if (rf_valid[1][idx] && rf_tag[1][idx] == tg) begin exp_hit = 1'b1; w = 1; end
        exp_wb        = !exp_hit && rf_valid[v][idx] && rf_dirty[v][idx];
        exp_wb_addr   = {rf_tag[v][idx], idx, 4'h0};
        exp_fill_addr = {addr[15:4], 4'h0};

        {wb_seen, fill_seen, done, stray, wb_sel_obs} = '0;
        wb_addr_obs = '0; fill_addr_obs = '0;
        fill_c = -1; resp_c = -1; pm_cnt = 0; pm_tgt = $urandom_range(0, 3);

        @(negedge clk);
        bus.mem_address = addr;
        bus.mem_read    = !wr || both;
        bus.mem_write   = wr;
        if ($urandom_range(0, 3) == 0) bus.pmem_resp = 1'b1;  // stray response while IDLE
        for (int c = 1; c <= 200 && !done; c++) begin
            next_cycle();
            if (bus.pmem_write) begin
                wb_seen = 1'b1; wb_addr_obs = bus.pmem_address; wb_sel_obs = pmem_w_mux_sel;
            end
            if (bus.pmem_read) begin
                fill_seen = 1'b1; fill_addr_obs = bus.pmem_address;
            end
            if (bus.pmem_read || bus.pmem_write) begin
                if (pm_cnt == pm_tgt) begin
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_read) fill_c = c;
                    pm_cnt = 0;
                    pm_tgt = $urandom_range(0, 3);
                end else pm_cnt++;
            end else if ($urandom_range(0, 3) == 0) begin
                bus.pmem_resp = 1'b1;
            end
            #1;
            if (fill_c == c) begin
                got_fill = {load_set_one, load_set_two, write_type_set_one, write_type_set_two,
                            cache_in_mux_sel, bus.mem_resp, load_lru};
                exp_fill = {v == 0, v == 1, 5'b0};
                check("fill_ctl", 32'(got_fill), 32'(exp_fill));
            end
            if (load_lru && !bus.mem_resp) stray = 1'b1;
            if ((load_set_one || load_set_two) && !bus.mem_resp && fill_c != c) stray = 1'b1;
            capture_loads();
            if (bus.mem_resp) begin
                resp_c  = c;
                done    = 1'b1;
                got_ctl = {load_lru, load_set_one, load_set_two, write_type_set_one,
                           write_type_set_two, cache_in_mux_sel, insert_enable,
                           bus.pmem_read, bus.pmem_write};
                exp_ctl = {1'b1, wr && w == 0, wr && w == 1, wr && w == 0, wr && w == 1,
                           wr, wr, 2'b00};
                check("resp_ctl", 32'(got_ctl), 32'(exp_ctl));
                bus.mem_read  = 1'b0;
                bus.mem_write = 1'b0;
            end
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        check("resp_seen", 32'(done), 1);
        check("stray_load", 32'(stray), 0);
        if (exp_hit) begin
            check("hit_latency", resp_c, 1);
            check("hit_no_pmem", 32'({wb_seen, fill_seen}), 0);
        end else begin
            check("fill_addr", 32'(fill_addr_obs), 32'(exp_fill_addr));
            check("wb_taken", 32'(wb_seen), 32'(exp_wb));
            if (exp_wb) begin
                check("wb_addr", 32'(wb_addr_obs), 32'(exp_wb_addr));
                check("wb_sel", 32'(wb_sel_obs), v);
            end
            check("miss_latency", resp_c, fill_c + 1);
        end

        next_cycle();
        check("idle_after", 32'(out_vec()), 0);
        if (exp_hit) rf_hits = sat(rf_hits);
        else begin
            rf_misses = sat(rf_misses);
            if (exp_wb) rf_wbs = sat(rf_wbs);
            rf_valid[v][idx] = 1'b1;
            rf_dirty[v][idx] = 1'b0;
            rf_tag[v][idx]   = tg;
        end
        if (wr) rf_dirty[w][idx] = 1'b1;
        rf_lru[idx] = (w == 0);
        check_counters("txn");
        check("line_state",
              32'({dp_valid[0][idx], dp_valid[1][idx], dp_dirty[0][idx], dp_dirty[1][idx],
                   dp_lru[idx], dp_tag[0][idx], dp_tag[1][idx]}),
              32'({rf_valid[0][idx], rf_valid[1][idx], rf_dirty[0][idx], rf_dirty[1][idx],
                   rf_lru[idx], rf_tag[0][idx], rf_tag[1][idx]}));
    endtask

    // a read held high: every response is a fresh hit, two cycles apart
    task automatic run_held_hits(input logic [15:0] addr, input int n);
        int   pulses, last_c, base, w;
        logic gap_bad, pmem_seen;
        logic [2:0] idx;
        idx = addr[6:4];
        w = (rf_valid[0][idx] && rf_tag[0][idx] == addr[15:7]) ? 0 : 1;
        base = rf_hits; pulses = 0; last_c = 0; gap_bad = 1'b0; pmem_seen = 1'b0;
        @(negedge clk);
        bus.mem_address = addr;
        bus.mem_read    = 1'b1;
        for (int c = 1; c <= 2 * n + 20 && pulses < n; c++) begin
            next_cycle();
            if (bus.pmem_read || bus.pmem_write) pmem_seen = 1'b1;
            if (!bus.mem_resp && pulses == 100) check("hit_count_mid", 32'(hit_count), base + 100);
            capture_loads();
            if (bus.mem_resp) begin
                if ((pulses == 0 && c != 1) || (pulses > 0 && c - last_c != 2)) gap_bad = 1'b1;
                pulses++;
                last_c = c;
            end
        end
        bus.mem_read = 1'b0;
        next_cycle();
        rf_hits = (base + pulses > CNT_MAX) ? CNT_MAX : base + pulses;
        rf_lru[idx] = (w == 0);
        check("held_pulses", pulses, n);
        check("held_spacing", 32'(gap_bad), 0);
        check("held_no_pmem", 32'(pmem_seen), 0);
        check("hit_saturated", 32'(hit_count), CNT_MAX);
        check_counters("held");
    endtask

    task automatic reset_during_writeback();
        logic found;
        found = 1'b0;
        preload(1, 3, 9'h1A5, 1'b1);
        preload(0, 3, 9'h0FF, 1'b0);
        dp_lru[3] = 1'b1; rf_lru[3] = 1'b1;
        @(negedge clk);
        bus.mem_address = 16'h0030;
        bus.mem_write   = 1'b1;
        for (int c = 1; c <= 10 && !found; c++) begin
            next_cycle();
            capture_loads();
            if (bus.pmem_write) found = 1'b1;
        end
        check("rst_wb_reached", 32'(found), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_pmem_write", 32'(bus.pmem_write), 0);
        check("rst_outputs", 32'(out_vec()), 0);
        check("rst_counters", 32'({hit_count, miss_count, wb_count}), 0);
        bus.mem_write = 1'b0;
        rf_hits = 0; rf_misses = 0; rf_wbs = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            check("rst_idle", 32'({out_vec(), bus.pmem_address}), 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0; bus.pmem_resp = 1'b0;
        {p_ld1, p_ld2, p_wt1, p_wt2, p_lru, p_hit1} = '0; p_idx = '0; p_tag = '0;
        for (int wy = 0; wy < 2; wy++)
            for (int i = 0; i < 8; i++) begin
                dp_valid[wy][i] = 1'b0; dp_dirty[wy][i] = 1'b0; dp_tag[wy][i] = '0;
                rf_valid[wy][i] = 1'b0; rf_dirty[wy][i] = 1'b0; rf_tag[wy][i] = '0;
            end
        for (int i = 0; i < 8; i++) begin dp_lru[i] = 1'b0; rf_lru[i] = 1'b0; end
        rf_hits = 0; rf_misses = 0; rf_wbs = 0;

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({out_vec(), bus.pmem_address}), 0);
        check_counters("reset");
        reset_n = 1'b1;

        run_req(1'b0, 1'b0, 16'h0123);   // cold read miss into set one
        run_req(1'b0, 1'b0, 16'h0923);   // same set, fills set two
        run_req(1'b0, 1'b0, 16'h0925);   // read hit in set two
        run_req(1'b1, 1'b0, 16'h0127);   // write hit in set one
        preload(0, 5, 9'h004, 1'b0);
        preload(1, 5, 9'h004, 1'b0);
        run_req(1'b1, 1'b1, 16'h0252);   // double hit: set one wins
        preload(1, 3, 9'h1A5, 1'b1);
        preload(0, 3, 9'h0FF, 1'b0);
        dp_lru[3] = 1'b1; rf_lru[3] = 1'b1;
        run_req(1'b1, 1'b0, 16'h0030);   // dirty victim: writeback 0xD2B0 first

        for (int i = 0; i < 150; i++) begin
            logic [15:0] a;
            logic        wr;
            a  = {7'h00, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15))};
            wr = 1'($urandom_range(0, 1));
            run_req(wr, wr && ($urandom_range(0, 3) == 0), a);
        end

        reset_during_writeback();
        run_req(1'b1, 1'b0, 16'h0030);   // dirty miss from fresh counters
        run_req(1'b0, 1'b0, 16'h0925);
        run_held_hits(16'h0925, CNT_MAX + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
